clk_div_prog: RTL

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog.sv | 92 +++++++++
 1 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider producing a square or pulse output.
// New divisors and modes take effect only at period boundaries.
module clk_div_prog #(
    parameter int WIDTH       = 28,
    parameter int DEFAULT_DIV = 200_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             slow_clk,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] active_div;
    logic             active_mode;
    logic [WIDTH-1:0] pend_div;
    logic             pend_mode;
    logic             pend_valid;
    logic [WIDTH-1:0] cnt;

    logic [WIDTH-1:0] load_div;
    logic [WIDTH-1:0] nxt_cnt;
    logic [WIDTH-1:0] nxt_div;
    logic             nxt_mode;
    logic             wrap;
    logic [WIDTH:0]   half;

    always_comb begin
        load_div = (div_in < MIN_DIV) ? MIN_DIV : div_in;
        // >= keeps the counter bounded even if it were ever out of range
        wrap     = en && (cnt >= active_div - ONE);
        nxt_cnt  = cnt;
        nxt_div  = active_div;
        nxt_mode = active_mode;
        if (en) begin
            nxt_cnt = wrap ? '0 : cnt + ONE;
        end
        if (wrap) begin
            if (div_load) begin
                nxt_div  = load_div;
                nxt_mode = mode;
            end else if (pend_valid) begin
                nxt_div  = pend_div;
                nxt_mode = pend_mode;
            end
        end
        half = ({1'b0, nxt_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_div  <= DEF_DIV;
            active_mode <= 1'b0;
            pend_div    <= DEF_DIV;
            pend_mode   <= 1'b0;
            pend_valid  <= 1'b0;
            cnt         <= DEF_DIV - ONE;
            slow_clk    <= 1'b0;
            tick        <= 1'b0;
        end else begin
            cnt         <= nxt_cnt;
            active_div  <= nxt_div;
            active_mode <= nxt_mode;
            // a load in the boundary cycle is applied directly, never pended
            if (wrap) begin
                pend_valid <= 1'b0;
            end else if (div_load) begin
                pend_div   <= load_div;
                pend_mode  <= mode;
                pend_valid <= 1'b1;
            end
            if (en) begin
                tick     <= (nxt_cnt == '0);
                slow_clk <= nxt_mode ? (nxt_cnt == '0)
                                     : ({1'b0, nxt_cnt} < half);
            end else begin
                tick <= 1'b0;
            end
        end
    end

    assign busy = pend_valid;

endmodule
